// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NopInstr = 32'h0000_0013;
  localparam logic [XLEN-1:0] ResetPcDefault = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of IF/ID entries with clear; no internal bypass.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  if_id_t                   push_data,
  input  logic                     pop,
  output if_id_t                   head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  if_id_t          mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CntW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited memory requests, response FIFO and IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = XLEN,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = ResetPcDefault,
  parameter int unsigned           QDEPTH     = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = NopInstr
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD
);

  localparam int unsigned CntW = $clog2(QDEPTH) + 1;
  localparam logic [CntW:0] QLimit = (CntW + 1)'(QDEPTH);

  logic [DATA_WIDTH-1:0] pcf_q, pcf_d, resp_pc;
  logic [CntW-1:0]       out_q, out_d, drop_q, drop_d, fifo_count;
  logic [CntW:0]         inflight;
  if_id_t                ifid_q, ifid_d, fifo_head, resp_entry;
  logic                  accept, resp_keep, resp_drop, fifo_empty;
  logic                  fifo_push, fifo_pop, fifo_clr;

  assign inflight       = {1'b0, out_q} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && (inflight < QLimit) && !PCSrcE;
  assign imem_req_addr  = pcf_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign resp_keep      = imem_resp_valid && (drop_q == '0);
  assign resp_drop      = imem_resp_valid && (drop_q != '0);
  assign fifo_empty     = (fifo_count == '0);

  // With nothing left to drop, all outstanding requests are contiguous and end at PCF-4,
  // so the oldest one (this response) sits out_q words behind PCF.
  assign resp_pc    = pcf_q - (DATA_WIDTH'(out_q) << 2);
  assign resp_entry = '{instr: imem_resp_data, pc: resp_pc, pc4: resp_pc + DATA_WIDTH'(4),
                        valid: 1'b1};

  fetch_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (fifo_clr),
    .push      (fifo_push),
    .push_data (resp_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    pcf_d     = pcf_q;
    drop_d    = drop_q;
    ifid_d    = ifid_q;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    fifo_clr  = 1'b0;
    out_d     = out_q + CntW'(accept) - CntW'(imem_resp_valid);

    if (PCSrcE) begin
      // Everything still in flight after this edge belongs to the wrong path.
      pcf_d        = PCTargetE;
      fifo_clr     = 1'b1;
      drop_d       = out_q - CntW'(imem_resp_valid);
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
    end else begin
      if (accept) pcf_d = pcf_q + DATA_WIDTH'(4);
      drop_d = drop_q - CntW'(resp_drop);
      if (FlushD) begin
        fifo_push    = resp_keep;
        ifid_d.instr = NOP_INSTR;
        ifid_d.valid = 1'b0;
      end else if (StallD) begin
        fifo_push = resp_keep;
      end else if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        fifo_push = resp_keep;
        ifid_d    = fifo_head;
      end else if (resp_keep) begin
        ifid_d = resp_entry;
      end else begin
        ifid_d.instr = NOP_INSTR;
        ifid_d.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcf_q  <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
      ifid_q <= '{instr: NOP_INSTR, pc: '0, pc4: DATA_WIDTH'(4), valid: 1'b0};
    end else begin
      pcf_q  <= pcf_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      ifid_q <= ifid_d;
    end
  end

  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pc4;
  assign ValidD   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed corner sequences and a randomized program-order model.
module tb_fetch_unit;

  localparam int unsigned QD     = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data;
  logic        StallD, FlushD, PCSrcE, ValidD;
  logic [31:0] PCTargetE, InstrD, PCD, PCPlus4D;

  fetch_unit #(
    .DATA_WIDTH (32),
    .RESET_PC   (RST_PC),
    .QDEPTH     (QD),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .StallD          (StallD),
    .FlushD          (FlushD),
    .PCSrcE          (PCSrcE),
    .PCTargetE       (PCTargetE),
    .InstrD          (InstrD),
    .PCD             (PCD),
    .PCPlus4D        (PCPlus4D),
    .ValidD          (ValidD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] target;
    logic        exp_valid;
    logic [31:0] exp_pcd;
  } vec_t;

  mreq_t       mem_q[$];
  vec_t        vecs[15];
  int          edge_n, lat_min, lat_max;
  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  logic [31:0] exp_dec_pc, exp_fetch_pc, m_pcd;
  logic        m_valid;
  logic        p_rst, p_stall, p_flush, p_redir, p_req_valid, p_req_ready;
  logic [31:0] p_addr, p_target;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] t,
                              input logic v, input logic [31:0] p);
    vec_t x;
    x.stall = s; x.flush = f; x.redir = r; x.target = t; x.exp_valid = v; x.exp_pcd = p;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decode sees instructions in program order; only their timing is left open.
  task automatic check_edge();
    if (p_rst) begin
      m_valid = 1'b0;
      m_pcd   = 32'h0;
    end else if (p_redir || p_flush) begin
      m_valid = 1'b0;
    end else if (!p_stall) begin
      if (ValidD === 1'b1) begin
        m_valid = 1'b1;
        m_pcd   = exp_dec_pc;
        exp_dec_pc += 32'd4;
        delivered++;
      end else begin
        m_valid = 1'b0;
      end
    end
    chk("ValidD", {31'b0, ValidD}, {31'b0, m_valid});
    chk("PCD", PCD, m_pcd);
    chk("PCPlus4D", PCPlus4D, m_pcd + 32'd4);
    chk("InstrD", InstrD, m_valid ? mem_word(m_pcd) : NOP);
  endtask

  task automatic tick();
    logic        acc, rsp;
    logic [31:0] acc_addr;
    int          lat;
    @(negedge clk);
    if (edge_n > 0) check_edge();
    if (!p_rst && !rst && p_req_valid && !p_req_ready && !p_redir && !PCSrcE) begin
      chk("addr_hold", imem_req_addr, p_addr);
      chk("valid_hold", {31'b0, imem_req_valid}, 32'd1);
    end
    if (rst) chk("valid_in_reset", {31'b0, imem_req_valid}, 32'd0);
    acc      = imem_req_valid && imem_req_ready;
    rsp      = imem_resp_valid;
    acc_addr = imem_req_addr;
    if (acc) chk("req_addr", acc_addr, exp_fetch_pc);
    p_rst = rst; p_stall = StallD; p_flush = FlushD; p_redir = PCSrcE; p_target = PCTargetE;
    p_req_valid = imem_req_valid; p_req_ready = imem_req_ready; p_addr = imem_req_addr;
    @(posedge clk);
    edge_n++;
    if (p_rst) begin
      mem_q.delete();
      exp_fetch_pc = RST_PC;
      exp_dec_pc   = RST_PC;
    end else begin
      if (rsp) void'(mem_q.pop_front());
      if (acc) begin
        lat = int'($urandom_range(lat_max, lat_min));
        mem_q.push_back('{addr: acc_addr, due: edge_n + lat});
      end
      if (p_redir) begin
        exp_fetch_pc = p_target;
        exp_dec_pc   = p_target;
      end else if (acc) begin
        exp_fetch_pc += 32'd4;
      end
      checks++;
      if (mem_q.size() > QD) begin
        errors++;
        $display("FAIL credit: outstanding %0d exceeds %0d", mem_q.size(), QD);
      end
    end
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= edge_n + 1) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          found;
    logic [31:0] saved;

    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    m_valid = 1'b0; m_pcd = 32'h0; exp_dec_pc = RST_PC; exp_fetch_pc = RST_PC;
    p_rst = 1'b1; edge_n = 0; lat_min = 1; lat_max = 1;

    // Zero-wait stream, a 3-cycle stall, then redirect coinciding with stall and a response.
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h00);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h00);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h04);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h08);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h08);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h08);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h08);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0C);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10);
    vecs[10] = mk(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h14);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h14);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h14);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104);

    @(posedge clk);
    #1;
    edge_n = 1;
    chk("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    chk("reset_instr", InstrD, NOP);
    chk("reset_validd", {31'b0, ValidD}, 32'd0);
    rst = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, RST_PC);

    for (int i = 0; i < 15; i++) begin
      StallD = vecs[i].stall; FlushD = vecs[i].flush;
      PCSrcE = vecs[i].redir; PCTargetE = vecs[i].target;
      chk($sformatf("vec%0d_validd", i), {31'b0, ValidD}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_pcd", i), PCD, vecs[i].exp_pcd);
      tick();
    end
    StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;

    // Redirect with two slow requests in flight.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (mem_q.size() == 2) found = 1'b1;
    end
    chk("two_in_flight", {31'b0, found}, 32'd1);
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h200;
    tick();
    PCSrcE = 1'b0; FlushD = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (ValidD === 1'b1) found = 1'b1;
    end
    chk("redirect_reached", {31'b0, found}, 32'd1);
    chk("redirect_first_pcd", PCD, 32'h200);

    // Backpressure: address must hold, decode drains to bubbles, then resumes in order.
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b0;
    tick();
    saved = imem_req_addr;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("bp_addr_stable", imem_req_addr, saved);
    end
    chk("bp_bubble", {31'b0, ValidD}, 32'd0);
    saved = exp_dec_pc;
    imem_req_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (ValidD === 1'b1) found = 1'b1;
    end
    chk("bp_resumed", {31'b0, found}, 32'd1);
    chk("bp_resume_pcd", PCD, saved);

    // Randomized traffic: variable latency, backpressure, stalls, redirects, one mid-run reset.
    lat_min = 1; lat_max = 4;
    saved = delivered;
    for (int c = 0; c < 1500; c++) begin
      rst            = (c == 700);
      imem_req_ready = ($urandom_range(99) < 70);
      StallD         = ($urandom_range(99) < 20);
      if (!rst && $urandom_range(99) < 4) begin
        PCSrcE    = 1'b1;
        FlushD    = 1'b1;
        PCTargetE = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      end else begin
        PCSrcE = 1'b0;
        FlushD = 1'b0;
      end
      tick();
    end
    rst = 1'b0; PCSrcE = 1'b0; FlushD = 1'b0; StallD = 1'b0;
    tick();
    checks++;
    if (delivered - int'(saved) < 200) begin
      errors++;
      $display("FAIL random_progress: got %0d instructions expected at least 200",
               delivered - int'(saved));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
